spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clk_div.sv | 37 +++
 rtl/spi_master.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, datapath and
// counter widths, and a small helper used by the transfer sequencer.
package spi_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned DIV_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 3'd7;

  // True when the bit counter addresses the final bit of the byte.
  function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
    return (cnt == LAST_BIT);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Phase-tick generator for the SPI master. Produces a single-cycle tick every
// CLK_DIV clk cycles. A synchronous clear holds the counter at zero so the
// first tick after release lands exactly CLK_DIV cycles later.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
)
(
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] r_cnt;
  logic                 w_at_last;

  assign w_at_last = (r_cnt == DIV_LAST);
  assign o_tick    = w_at_last & ~i_clr;

  // Phase counter: wraps at CLK_DIV-1, held at zero while cleared or in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (w_at_last) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 toward the slave, one byte per transfer, MSB first.
// miso is captured at sclk falling edges because the slave updates on rising
// edges; mosi only moves while sclk is low or at a falling edge.
// Optional feature: define SPI_MASTER_BURST_EN to let start in the final HOLD
// cycle chain the next byte without releasing cs.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs
);

  spi_state_t r_state;
  spi_state_t w_state_nxt;

  logic w_tick;
  logic w_div_clr;
  logic w_burst;

  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BIT_CNT_W-1:0] w_bit_cnt_nxt;
  logic [DATA_W-1:0]    r_tx_shift;
  logic [DATA_W-1:0]    w_tx_shift_nxt;
  logic [DATA_W-1:0]    r_rx_shift;
  logic [DATA_W-1:0]    w_rx_shift_nxt;
  logic [DATA_W-1:0]    r_rx_data;
  logic [DATA_W-1:0]    w_rx_data_nxt;

  logic r_cs,   w_cs_nxt;
  logic r_sclk, w_sclk_nxt;
  logic r_mosi, w_mosi_nxt;
  logic r_busy, w_busy_nxt;
  logic r_done, w_done_nxt;

  // Divider idles cleared so a newly accepted transfer starts a fresh phase.
  assign w_div_clr = (r_state == IDLE);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_div_clr),
    .o_tick (w_tick)
  );

`ifdef SPI_MASTER_BURST_EN
  assign w_burst = (r_state == HOLD) & w_tick & start;
`else
  assign w_burst = 1'b0;
`endif

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: SETUP holds one phase, XFER runs 16 edges, HOLD one phase.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SETUP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_state_nxt = XFER;
        end else begin
          w_state_nxt = SETUP;
        end
      end
      XFER: begin
        if (w_tick && r_sclk && is_last_bit(r_bit_cnt)) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = XFER;
        end
      end
      HOLD: begin
        if (w_tick) begin
          if (w_burst) begin
            w_state_nxt = SETUP;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output/datapath next values; everything here is registered below.
  always_comb begin
    w_cs_nxt       = r_cs;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_rx_data_nxt  = r_rx_data;
    w_tx_shift_nxt = r_tx_shift;
    w_rx_shift_nxt = r_rx_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_cs_nxt       = 1'b0;
          w_busy_nxt     = 1'b1;
          w_sclk_nxt     = 1'b0;
          w_mosi_nxt     = tx_data[DATA_W-1];
          w_tx_shift_nxt = {tx_data[DATA_W-2:0], 1'b0};
          w_rx_shift_nxt = 8'h00;
          w_bit_cnt_nxt  = 3'd0;
        end else begin
          w_cs_nxt   = 1'b1;
          w_busy_nxt = 1'b0;
          w_sclk_nxt = 1'b0;
          w_mosi_nxt = 1'b0;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_sclk_nxt = 1'b1;
        end else begin
          w_sclk_nxt = r_sclk;
        end
      end
      XFER: begin
        if (w_tick) begin
          if (r_sclk) begin
            // Falling edge: capture miso, then present the next tx bit.
            w_sclk_nxt     = 1'b0;
            w_rx_shift_nxt = {r_rx_shift[DATA_W-2:0], miso};
            if (!is_last_bit(r_bit_cnt)) begin
              w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
              w_mosi_nxt     = r_tx_shift[DATA_W-1];
              w_tx_shift_nxt = {r_tx_shift[DATA_W-2:0], 1'b0};
            end else begin
              w_bit_cnt_nxt = r_bit_cnt;
            end
          end else begin
            w_sclk_nxt = 1'b1;
          end
        end else begin
          w_sclk_nxt = r_sclk;
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx_shift;
          if (w_burst) begin
            w_cs_nxt       = 1'b0;
            w_busy_nxt     = 1'b1;
            w_sclk_nxt     = 1'b0;
            w_mosi_nxt     = tx_data[DATA_W-1];
            w_tx_shift_nxt = {tx_data[DATA_W-2:0], 1'b0};
            w_rx_shift_nxt = 8'h00;
            w_bit_cnt_nxt  = 3'd0;
          end else begin
            w_cs_nxt   = 1'b1;
            w_busy_nxt = 1'b0;
            w_sclk_nxt = 1'b0;
            w_mosi_nxt = 1'b0;
          end
        end else begin
          w_sclk_nxt = r_sclk;
        end
      end
      default: begin
        w_cs_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_sclk_nxt = 1'b0;
        w_mosi_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset forces the idle bus state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs       <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rx_data  <= 8'h00;
      r_tx_shift <= 8'h00;
      r_rx_shift <= 8'h00;
      r_bit_cnt  <= 3'd0;
    end else begin
      r_cs       <= w_cs_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
    end
  end

  assign cs      = r_cs;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: instance A uses CLK_DIV=4, instance B uses
// CLK_DIV=1. Stimulus pushes expected {tx byte, rx byte, done cycle, cs} and
// per-instance monitors pop and compare on every done pulse.
module tb_spi_master;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         cyc;
    logic       cs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_start, a_busy, a_done, a_sclk, a_mosi, a_miso, a_cs;
  logic [7:0] a_tx, a_rx;
  logic       b_start, b_busy, b_done, b_sclk, b_mosi, b_miso, b_cs;
  logic [7:0] b_tx, b_rx;

  spi_master #(.CLK_DIV(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .tx_data(a_tx), .busy(a_busy),
    .done(a_done), .rx_data(a_rx), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso), .cs(a_cs)
  );

  spi_master #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .tx_data(b_tx), .busy(b_busy),
    .done(b_done), .rx_data(b_rx), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso), .cs(b_cs)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;
  int a_viol = 0;
  int b_viol = 0;

  // cycle counter: value N during the cycle in which start is sampled = cycle 0
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // slave models: byte loaded at the first rising edge, MSB first, update on rising edge
  logic [7:0] a_slv_byte = 8'h00, a_slv_sh = 8'h00, a_mcap = 8'h00;
  logic [7:0] b_slv_byte = 8'h00, b_slv_sh = 8'h00, b_mcap = 8'h00;
  int a_idx = 0;
  int b_idx = 0;
  initial begin a_miso = 1'b0; b_miso = 1'b0; end

  always @(posedge a_sclk or posedge a_cs or posedge reset) begin
    if (reset || a_cs) begin
      a_idx = 0;
    end else begin
      if (a_idx == 0) a_slv_sh = a_slv_byte;
      a_miso   = a_slv_sh[7];
      a_slv_sh = {a_slv_sh[6:0], 1'b0};
      a_idx    = (a_idx + 1) % 8;
      a_mcap   = {a_mcap[6:0], a_mosi};
    end
  end

  always @(posedge b_sclk or posedge b_cs or posedge reset) begin
    if (reset || b_cs) begin
      b_idx = 0;
    end else begin
      if (b_idx == 0) b_slv_sh = b_slv_byte;
      b_miso   = b_slv_sh[7];
      b_slv_sh = {b_slv_sh[6:0], 1'b0};
      b_idx    = (b_idx + 1) % 8;
      b_mcap   = {b_mcap[6:0], b_mosi};
    end
  end

  // monitors
  always @(negedge clk) begin
    if (a_cs && a_sclk) a_viol++;
    if (a_done) begin
      if (a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        a_e = a_q.pop_front();
        check("a_rx_data", 32'(a_rx), 32'(a_e.rx));
        check("a_mosi_byte", 32'(a_mcap), 32'(a_e.tx));
        check("a_done_cycle", 32'(cyc), 32'(a_e.cyc));
        check("a_cs_at_done", 32'(a_cs), 32'(a_e.cs));
      end
    end
  end

  always @(negedge clk) begin
    if (b_cs && b_sclk) b_viol++;
    if (b_done) begin
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        b_e = b_q.pop_front();
        check("b_rx_data", 32'(b_rx), 32'(b_e.rx));
        check("b_mosi_byte", 32'(b_mcap), 32'(b_e.tx));
        check("b_done_cycle", 32'(cyc), 32'(b_e.cyc));
        check("b_cs_at_done", 32'(b_cs), 32'(b_e.cs));
      end
    end
  end

  // start one transfer on A at the current negedge (cycle 0), return in cycle 1
  task automatic go_a(input logic [7:0] tx, input logic [7:0] slv);
    a_tx = tx; a_slv_byte = slv; a_start = 1'b1;
    a_q.push_back('{tx, slv, cyc + 1 + 17 * 4, 1'b1});
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic go_b(input logic [7:0] tx, input logic [7:0] slv);
    b_tx = tx; b_slv_byte = slv; b_start = 1'b1;
    b_q.push_back('{tx, slv, cyc + 1 + 17 * 1, 1'b1});
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (a_busy && n < 400) begin @(negedge clk); n++; end
    if (a_busy) begin
      checks++; errors++;
      $display("FAIL a_idle_timeout actual=busy required=idle");
    end
    @(negedge clk);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (b_busy && n < 100) begin @(negedge clk); n++; end
    if (b_busy) begin
      checks++; errors++;
      $display("FAIL b_idle_timeout actual=busy required=idle");
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_tx = 8'h00;
    b_start = 1'b0; b_tx = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_a_cs", 32'(a_cs), 32'd1);
    check("rst_a_sclk", 32'(a_sclk), 32'd0);
    check("rst_a_mosi", 32'(a_mosi), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_done", 32'(a_done), 32'd0);
    check("rst_a_rx", 32'(a_rx), 32'h00);
    check("rst_b_cs", 32'(b_cs), 32'd1);
    check("rst_b_sclk", 32'(b_sclk), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 0xA5 out, 0x3C back, done at cycle 69
    go_a(8'hA5, 8'h3C);
    check("a_cycle1_cs", 32'(a_cs), 32'd0);
    check("a_cycle1_busy", 32'(a_busy), 32'd1);
    check("a_cycle1_mosi", 32'(a_mosi), 32'd1);
    wait_idle_a();
    repeat (3) @(negedge clk);
    check("a_rx_held", 32'(a_rx), 32'h3C);

    // start with 0xFF at cycle 10 of an active transfer must be ignored
    go_a(8'hC3, 8'h96);
    repeat (9) @(negedge clk);
    a_tx = 8'hFF; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_busy_during", 32'(a_busy), 32'd1);
    wait_idle_a();
    repeat (4) @(negedge clk);
    check("a_busy_after_ignore", 32'(a_busy), 32'd0);

    // reset at edge 5 (cycle 21) for one cycle aborts with no done
    go_a(8'h0F, 8'hF0);
    repeat (20) @(negedge clk);
    void'(a_q.pop_back());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cs", 32'(a_cs), 32'd1);
    check("abort_sclk", 32'(a_sclk), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_rx", 32'(a_rx), 32'h00);
    check("abort_mosi", 32'(a_mosi), 32'd0);
    repeat (4) @(negedge clk);
    check("abort_busy_later", 32'(a_busy), 32'd0);
    go_a(8'h5A, 8'hA5);
    wait_idle_a();

    // start held high: 0x11 then 0x22
    a_tx = 8'h11; a_slv_byte = 8'h33; a_start = 1'b1;
`ifdef SPI_MASTER_BURST_EN
    a_q.push_back('{8'h11, 8'h33, cyc + 69, 1'b0});
    a_q.push_back('{8'h22, 8'h44, cyc + 137, 1'b1});
`else
    a_q.push_back('{8'h11, 8'h33, cyc + 69, 1'b1});
    a_q.push_back('{8'h22, 8'h44, cyc + 138, 1'b1});
`endif
    @(negedge clk);
    a_tx = 8'h22;
    repeat (9) @(negedge clk);
    a_slv_byte = 8'h44;
    repeat (58) @(negedge clk);
    check("hold_cs_c68", 32'(a_cs), 32'd0);
    @(negedge clk);
`ifdef SPI_MASTER_BURST_EN
    check("burst_cs_c69", 32'(a_cs), 32'd0);
`else
    check("gap_cs_c69", 32'(a_cs), 32'd1);
`endif
    @(negedge clk);
    a_start = 1'b0;
    check("second_cs_c70", 32'(a_cs), 32'd0);
    wait_idle_a();

    // CLK_DIV=1: 0x81 out, 0x7E back, sclk toggles each cycle, done at cycle 18
    go_b(8'h81, 8'h7E);
    for (int c = 1; c <= 17; c++) begin
      check("b_sclk_toggle", 32'(b_sclk), 32'((c - 1) & 1));
      @(negedge clk);
    end
    wait_idle_b();

    repeat (5) @(negedge clk);
    check("a_queue_drained", 32'(a_q.size()), 32'd0);
    check("b_queue_drained", 32'(b_q.size()), 32'd0);
    check("a_sclk_low_when_cs_high", 32'(a_viol), 32'd0);
    check("b_sclk_low_when_cs_high", 32'(b_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
